// File: rtl/serializer_pkg.sv
// Shared types for the dual-word serializer: FSM state encoding and default word width.
package serializer_pkg;

   localparam int WIDTH_DEFAULT = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLR   = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_e;

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out register: parallel load, shift left with zero fill, MSB presented as the serial bit.
module piso_shift_reg
   import serializer_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             shift,
   input  logic             clr,
   input  logic [WIDTH-1:0] d,
   output logic             msb
);

   logic [WIDTH-1:0] sr;

   // clr wins so an aborted frame leaves no stale data behind
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr <= '0;
      end else if (clr) begin
         sr <= '0;
      end else if (load) begin
         sr <= d;
      end else if (shift) begin
         sr <= {sr[WIDTH-2:0], 1'b0};
      end
   end

   assign msb = sr[WIDTH-1];

endmodule

// File: rtl/dual_word_serializer.sv
// Loads an operand pair and streams both words MSB first, framed by a clear pulse and a done pulse.
module dual_word_serializer
   import serializer_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic             abort,
   output logic             x,
   output logic             y,
   output logic             bit_valid,
   output logic             cmp_clr,
   output logic             frame_last,
   output logic             done
);

   localparam int CW = $clog2(WIDTH);

   state_e          state;
   state_e          state_nx;
   logic [CW-1:0]   cnt;
   logic            sa_msb;
   logic            sb_msb;
   logic            load_hs;
   logic            shift_en;
   logic            clr_en;

   piso_shift_reg #(.WIDTH(WIDTH)) u_sa (
      .clk   (clk),
      .rst   (rst),
      .load  (load_hs),
      .shift (shift_en),
      .clr   (clr_en),
      .d     (a),
      .msb   (sa_msb)
   );

   piso_shift_reg #(.WIDTH(WIDTH)) u_sb (
      .clk   (clk),
      .rst   (rst),
      .load  (load_hs),
      .shift (shift_en),
      .clr   (clr_en),
      .d     (b),
      .msb   (sb_msb)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      load_hs  = 1'b0;
      shift_en = 1'b0;
      clr_en   = 1'b0;
      case (state)
         IDLE: begin
            if (load_valid) begin
               load_hs  = 1'b1;
               state_nx = CLR;
            end
         end
         CLR: begin
            if (abort) begin
               clr_en   = 1'b1;
               state_nx = IDLE;
            end else begin
               state_nx = SHIFT;
            end
         end
         SHIFT: begin
            if (abort) begin
               clr_en   = 1'b1;
               state_nx = IDLE;
            end else begin
               shift_en = 1'b1;
               if (cnt == '0) begin
                  state_nx = DONE;
               end
            end
         end
         DONE: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // counter holds at zero on the last bit so it never wraps
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr_en) begin
         cnt <= '0;
      end else if (state == CLR) begin
         cnt <= CW'(WIDTH - 1);
      end else if (shift_en && (cnt != '0)) begin
         cnt <= cnt - CW'(1);
      end
   end

   assign load_ready = (state == IDLE);
   assign cmp_clr    = (state == CLR);
   assign bit_valid  = (state == SHIFT);
   assign x          = bit_valid & sa_msb;
   assign y          = bit_valid & sb_msb;
   assign frame_last = bit_valid & (cnt == '0);
   assign done       = (state == DONE);

endmodule

// File: tb/tb_dual_word_serializer.sv
// Randomized and directed bench for dual_word_serializer (WIDTH=8 with a serial comparator, plus WIDTH=2).
module tb_dual_word_serializer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   int         pass_cnt = 0;
   int         total_cnt = 0;

   logic [7:0] a8 = '0, b8 = '0;
   logic       lv8 = 1'b0, ab8 = 1'b0;
   logic       lr8, x8, y8, bv8, cc8, fl8, dn8;

   logic [1:0] a2 = '0, b2 = '0;
   logic       lv2 = 1'b0, ab2 = 1'b0;
   logic       lr2, x2, y2, bv2, cc2, fl2, dn2;

   logic [1:0] cmp_out;

   always #5 clk = ~clk;

   dual_word_serializer #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .a(a8), .b(b8), .load_valid(lv8), .load_ready(lr8),
      .abort(ab8), .x(x8), .y(y8), .bit_valid(bv8), .cmp_clr(cc8),
      .frame_last(fl8), .done(dn8)
   );

   dual_word_serializer #(.WIDTH(2)) dut2 (
      .clk(clk), .rst(rst), .a(a2), .b(b2), .load_valid(lv2), .load_ready(lr2),
      .abort(ab2), .x(x2), .y(y2), .bit_valid(bv2), .cmp_clr(cc2),
      .frame_last(fl2), .done(dn2)
   );

   // Downstream MSB-first serial comparator: 0 equal, 1 A>B, 2 A<B; first differing bit decides.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cmp_out <= 2'd0;
      end else if (cc8) begin
         cmp_out <= 2'd0;
      end else if (bv8 && (cmp_out == 2'd0) && (x8 != y8)) begin
         cmp_out <= x8 ? 2'd1 : 2'd2;
      end
   end

   // Expected {load_ready, cmp_clr, bit_valid, x, y, frame_last, done} in cycle k after a handshake.
   function automatic logic [6:0] exp_vec(input int k, input int unsigned av, input int unsigned bv,
                                          input int w);
      logic lr, cc, vb, xx, yy, fl, dn;
      lr = (k <= 0) || (k >= w + 3);
      cc = (k == 1);
      vb = (k >= 2) && (k <= w + 1);
      xx = vb ? 1'((av >> (w + 1 - k)) & 1) : 1'b0;
      yy = vb ? 1'((bv >> (w + 1 - k)) & 1) : 1'b0;
      fl = (k == w + 1);
      dn = (k == w + 2);
      return {lr, cc, vb, xx, yy, fl, dn};
   endfunction

   function automatic logic [1:0] exp_cmp(input int unsigned av, input int unsigned bv);
      return (av > bv) ? 2'd1 : ((av < bv) ? 2'd2 : 2'd0);
   endfunction

   function automatic logic [6:0] obs8();
      return {lr8, cc8, bv8, x8, y8, fl8, dn8};
   endfunction

   task automatic run_frame8(input logic [7:0] av, input logic [7:0] bv, input string tag);
      logic [6:0] e, o;
      a8  = av;
      b8  = bv;
      lv8 = 1'b1;
      for (int k = 1; k <= 11; k++) begin
         @(posedge clk);
         #1 lv8 = 1'b0;
         @(negedge clk);
         e = exp_vec(k, av, bv, 8);
         o = obs8();
         total_cnt++;
         if (o !== e) $display("FAIL %s cycle %0d: got %b expected %b", tag, k, o, e);
         else pass_cnt++;
         if (k == 10) begin
            total_cnt++;
            if (cmp_out !== exp_cmp(av, bv))
               $display("FAIL %s cmp_out at done: got %0d expected %0d", tag, cmp_out, exp_cmp(av, bv));
            else pass_cnt++;
         end
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      total_cnt++;
      if ({obs8(), lr2, cc2, bv2, x2, y2, fl2, dn2} !== {7'b1000000, 7'b1000000})
         $display("FAIL reset_held: got %b/%b expected 1000000", obs8(), {lr2, cc2, bv2, x2, y2, fl2, dn2});
      else pass_cnt++;
      rst = 1'b0;
      @(negedge clk);
      total_cnt++;
      if (obs8() !== 7'b1000000) $display("FAIL reset_release: got %b expected 1000000", obs8());
      else pass_cnt++;
   endtask

   task automatic test_directed();
      run_frame8(8'hA5, 8'h3C, "frame_a5_3c");
      run_frame8(8'hFF, 8'hFF, "cmp_equal");
      run_frame8(8'h80, 8'h7F, "cmp_a_gt_b");
   endtask

   task automatic test_random();
      for (int i = 0; i < 8; i++) begin
         logic [7:0] av, bv;
         av = 8'($urandom);
         bv = (i == 3) ? av : 8'($urandom);
         run_frame8(av, bv, "random");
      end
   endtask

   task automatic test_abort();
      logic [6:0] e;
      logic [7:0] av, bv;
      av = 8'($urandom);
      bv = 8'($urandom);
      a8 = av; b8 = bv; lv8 = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         @(posedge clk);
         #1 lv8 = 1'b0;
         @(negedge clk);
         e = exp_vec(k, av, bv, 8);
         total_cnt++;
         if (obs8() !== e) $display("FAIL abort_pre cycle %0d: got %b expected %b", k, obs8(), e);
         else pass_cnt++;
      end
      ab8 = 1'b1;
      @(posedge clk);
      #1 ab8 = 1'b0;
      @(negedge clk);
      total_cnt++;
      if (obs8() !== 7'b1000000) $display("FAIL abort_shift_next: got %b expected 1000000", obs8());
      else pass_cnt++;
      for (int j = 0; j < 8; j++) begin
         @(negedge clk);
         total_cnt++;
         if (obs8() !== 7'b1000000) $display("FAIL abort_quiet %0d: got %b expected 1000000", j, obs8());
         else pass_cnt++;
      end
      // abort while in CLR
      a8 = 8'h5A; b8 = 8'hC3; lv8 = 1'b1;
      @(posedge clk);
      #1 lv8 = 1'b0;
      @(negedge clk);
      ab8 = 1'b1;
      @(posedge clk);
      #1 ab8 = 1'b0;
      @(negedge clk);
      total_cnt++;
      if (obs8() !== 7'b1000000) $display("FAIL abort_clr_next: got %b expected 1000000", obs8());
      else pass_cnt++;
      // abort with load_valid in IDLE loads; abort in DONE is ignored
      av = 8'($urandom);
      bv = 8'($urandom);
      a8 = av; b8 = bv; lv8 = 1'b1; ab8 = 1'b1;
      for (int k = 1; k <= 11; k++) begin
         @(posedge clk);
         #1 begin lv8 = 1'b0; ab8 = 1'b0; end
         @(negedge clk);
         e = exp_vec(k, av, bv, 8);
         total_cnt++;
         if (obs8() !== e) $display("FAIL abort_ignored cycle %0d: got %b expected %b", k, obs8(), e);
         else pass_cnt++;
         if (k == 10) ab8 = 1'b1;
      end
   endtask

   task automatic test_back_to_back();
      logic [6:0] e;
      logic [7:0] pa, pb, qa, qb;
      pa = 8'($urandom); pb = 8'($urandom);
      qa = 8'($urandom); qb = 8'($urandom);
      a8 = pa; b8 = pb; lv8 = 1'b1;
      for (int k = 1; k <= 22; k++) begin
         @(posedge clk);
         #1 begin
            if (k == 1) begin a8 = qa; b8 = qb; end
            if (k == 12) lv8 = 1'b0;
         end
         @(negedge clk);
         e = (k <= 11) ? exp_vec(k, pa, pb, 8) : exp_vec(k - 11, qa, qb, 8);
         total_cnt++;
         if (obs8() !== e) $display("FAIL back_to_back cycle %0d: got %b expected %b", k, obs8(), e);
         else pass_cnt++;
      end
   endtask

   task automatic test_async_reset();
      logic [6:0] e;
      a8 = 8'hC9; b8 = 8'h36; lv8 = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk);
         #1 lv8 = 1'b0;
         @(negedge clk);
         e = exp_vec(k, 8'hC9, 8'h36, 8);
         total_cnt++;
         if (obs8() !== e) $display("FAIL async_pre cycle %0d: got %b expected %b", k, obs8(), e);
         else pass_cnt++;
      end
      #2 rst = 1'b1;
      #1;
      total_cnt++;
      if (obs8() !== 7'b1000000) $display("FAIL async_reset_immediate: got %b expected 1000000", obs8());
      else pass_cnt++;
      #1 rst = 1'b0;
      for (int j = 0; j < 12; j++) begin
         @(negedge clk);
         total_cnt++;
         if (obs8() !== 7'b1000000) $display("FAIL async_after %0d: got %b expected 1000000", j, obs8());
         else pass_cnt++;
      end
   endtask

   task automatic test_width2();
      logic [6:0] e, o;
      a2 = 2'b10; b2 = 2'b01; lv2 = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         @(posedge clk);
         #1 lv2 = 1'b0;
         @(negedge clk);
         e = exp_vec(k, 2, 1, 2);
         o = {lr2, cc2, bv2, x2, y2, fl2, dn2};
         total_cnt++;
         if (o !== e) $display("FAIL width2 cycle %0d: got %b expected %b", k, o, e);
         else pass_cnt++;
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_abort();
      test_back_to_back();
      test_async_reset();
      test_width2();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
